u409_tack_engine: RTL

- Parametrised multi-channel 68040 transfer-acknowledge generator for U409.
- Generalises the fixed per-space TACK logic: N decoded spaces, each with a runtime wait-state count, an optional external-ack mode (flash, RTC, autoconfig style), and per-space TBI/TCI policy.
- Sits between the address decoder (one-hot space hits) and the shared TACKn/TBIn/TCIn pins.
- Drives TACKn actively high for one cycle after the ack, so no slow pull-up is needed.

---
 rtl/u409_pkg.sv | 17 +
 rtl/u409_wait_counter.sv | 18 +
 rtl/u409_tack_engine.sv | 112 +++++++++++
 3 files changed

// File: rtl/u409_pkg.sv
// u409_pkg: shared states, channel-index helpers and default policy constants for the U409 TACK engine.
package u409_pkg;
    typedef enum logic [2:0] {IDLE, WAIT, ACK, RELEASE, ERR} state_t;
    localparam logic [7:0] TBI_MASK_DEF = 8'hFF;
    localparam logic [7:0] TCI_MASK_DEF = 8'h00;
    localparam int TO_CYCLES_DEF = 1023;
    function automatic int chw(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    function automatic logic [3:0] lowest(input logic [15:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 15; i >= 0; i--)
            if (v[i]) r = 4'(i);
        return r;
    endfunction
endpackage

// File: rtl/u409_wait_counter.sv
// u409_wait_counter: loadable down-counter with zero flag that saturates at 0.
module u409_wait_counter #(
    parameter int W = 4
) (
    input  logic         CLK40,
    input  logic         RESETn,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge CLK40)
        if (!RESETn) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en && !zero) cnt <= cnt - W'(1);
    assign zero = cnt == '0;
endmodule

// File: rtl/u409_tack_engine.sv
// u409_tack_engine: multi-channel 68040 TACKn/TBIn/TCIn generator with per-channel waits or external acks.
// Define U409_BUS_TIMEOUT_EN to add a bus-timeout timer that ends stuck cycles with TEAn.
module u409_tack_engine
    import u409_pkg::*;
#(
    parameter int            NCH       = 8,
    parameter int            WW        = 4,
    parameter logic [NCH-1:0] TBI_MASK = NCH'(TBI_MASK_DEF),
    parameter logic [NCH-1:0] TCI_MASK = NCH'(TCI_MASK_DEF),
    parameter int            TO_CYCLES = TO_CYCLES_DEF
) (
    input  logic                  CLK40,
    input  logic                  RESETn,
    input  logic                  TSn,
    input  logic [NCH-1:0]        SPACE_HIT,
    input  logic [NCH*WW-1:0]     WAIT_CFG,
    input  logic [NCH-1:0]        EXT_MODE,
    input  logic [NCH-1:0]        EXT_ACK,
    output logic                  TACK_O,
    output logic                  TACK_OE,
    output logic                  TBIn,
    output logic                  TCIn,
    output logic                  TEAn,
    output logic                  BUSY,
    output logic [chw(NCH)-1:0]   ACK_CH,
    output logic                  MULTI_HIT
);
    localparam int CW = chw(NCH);
    state_t          state;
    logic [3:0]      lo;
    logic [CW-1:0]   ch_n;
    logic            start, multi, ext_l, cnt_zero, done, to;
    assign lo    = lowest(16'(SPACE_HIT));
    assign ch_n  = lo[CW-1:0];
    assign start = state == IDLE && !TSn && |SPACE_HIT;
    assign multi = |(SPACE_HIT & (SPACE_HIT - NCH'(1)));
    assign done  = ext_l ? EXT_ACK[ACK_CH] : cnt_zero;
    u409_wait_counter #(.W(WW)) u_wait (
        .CLK40    (CLK40),
        .RESETn   (RESETn),
        .load     (start),
        .en       (state == WAIT && !ext_l),
        .load_val (WAIT_CFG[ch_n*WW +: WW]),
        .zero     (cnt_zero)
    );
`ifdef U409_BUS_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYCLES + 1) > 10 ? $clog2(TO_CYCLES + 1) : 10;
    u409_wait_counter #(.W(TW)) u_timer (
        .CLK40    (CLK40),
        .RESETn   (RESETn),
        .load     (start),
        .en       (state == WAIT),
        .load_val (TW'(TO_CYCLES - 1)),
        .zero     (to)
    );
`else
    assign to = 1'b0;
`endif
    always_ff @(posedge CLK40) begin
        if (!RESETn) begin
            state     <= IDLE;
            TACK_O    <= 1'b1;
            TACK_OE   <= 1'b0;
            TBIn      <= 1'b1;
            TCIn      <= 1'b1;
            TEAn      <= 1'b1;
            BUSY      <= 1'b0;
            ACK_CH    <= '0;
            MULTI_HIT <= 1'b0;
            ext_l     <= 1'b0;
        end else begin
            MULTI_HIT <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state     <= WAIT;
                    ACK_CH    <= ch_n;
                    ext_l     <= EXT_MODE[ch_n];
                    TBIn      <= !TBI_MASK[ch_n];
                    TCIn      <= !TCI_MASK[ch_n];
                    BUSY      <= 1'b1;
                    MULTI_HIT <= multi;
                end
                WAIT: if (done) begin
                    state   <= ACK;
                    TACK_O  <= 1'b0;
                    TACK_OE <= 1'b1;
                end else if (to) begin
                    state <= ERR;
                    TEAn  <= 1'b0;
                end
                ACK: begin
                    state  <= RELEASE;
                    TACK_O <= 1'b1;
                    TBIn   <= 1'b1;
                    TCIn   <= 1'b1;
                end
                ERR: begin
                    state <= RELEASE;
                    TEAn  <= 1'b1;
                    TBIn  <= 1'b1;
                    TCIn  <= 1'b1;
                end
                RELEASE: begin
                    state   <= IDLE;
                    TACK_OE <= 1'b0;
                    BUSY    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
